coherence_bus_ctrl: RTL

COHERENCE_BUS_CTRL -- requirements
Module: coherence_bus_ctrl

---
 rtl/coherence_bus_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/coherence_bus_ctrl.sv
// Snooping coherence bus controller: arbitrates L1 requests, runs one snoop cycle,
// then moves a block from L2 or a peer cache. Define BUS_CTRL_RR_ARB_EN for round-robin grant.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | wait for any dREN/dWEN, grant one requester
// SNOOP    | single-cycle snoop broadcast, pick lowest-index hitting peer
// RMEM     | block read from L2, one beat per l2ready
// TRANSFER | cache-to-cache supply, dirty non-exclusive also written to L2
// WMEM     | write-back of requester block to L2

module coherence_bus_ctrl #(
    parameter int CPUS       = 4,
    parameter int BLOCK_SIZE = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS-1:0]      readX,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]      dwait,
    output logic [31:0]          dload,
    output logic [CPUS-1:0]      ccwait,
    output logic [CPUS-1:0]      ccinv,
    output logic [31:0]          ccsnoopaddr,
    input  logic [CPUS-1:0]      ccsnoophit,
    input  logic [CPUS-1:0]      ccdirty,
    output logic [CPUS-1:0]      ccexclusive,
    output logic                 l2REN,
    output logic                 l2WEN,
    output logic [31:0]          l2addr,
    output logic [31:0]          l2store,
    input  logic [31:0]          l2load,
    input  logic                 l2ready
);

    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int BW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SNOOP    = 3'd1,
        RMEM     = 3'd2,
        TRANSFER = 3'd3,
        WMEM     = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   req_idx;
    logic [CW-1:0]   sup_idx;
    logic            sup_dirty;
    logic            op_readx;
    logic [31:0]     base_addr;
    logic [BW-1:0]   beat, beat_nxt;
    logic [31:0]     snoop_nxt;

    logic [CPUS-1:0] req_any;
    logic            grant_vld;
    logic [CW-1:0]   grant_idx;
    logic            sup_vld;
    logic [CW-1:0]   sup_sel;
    logic [CPUS-1:0] req_mask;
    logic [31:0]     beat_addr;
    logic [31:0]     next_addr;
    logic            last_beat;
    logic            beat_done;

    assign req_any   = dREN | dWEN;
    assign req_mask  = CPUS'(1) << req_idx;
    assign beat_addr = (base_addr + (32'(beat) << 2)) & 32'hFFFF_FFFC;
    assign next_addr = (base_addr + (32'(beat) << 2) + 32'd4) & 32'hFFFF_FFFC;
    assign last_beat = (beat == BW'(BLOCK_SIZE - 1));

`ifdef BUS_CTRL_RR_ARB_EN
    logic [CW-1:0] rr_ptr;

    // search upward from the pointer, wrapping past the top CPU
    always_comb begin
        int j;
        j         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < CPUS; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= CPUS)
                j = j - CPUS;
            if (!grant_vld && req_any[CW'(j)]) begin
                grant_vld = 1'b1;
                grant_idx = CW'(j);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            rr_ptr <= '0;
        else if (state == IDLE && grant_vld)
            rr_ptr <= (grant_idx == CW'(CPUS - 1)) ? '0 : grant_idx + 1'b1;
    end
`else
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = CPUS - 1; i >= 0; i--) begin
            if (req_any[i]) begin
                grant_vld = 1'b1;
                grant_idx = CW'(i);
            end
        end
    end
`endif

    always_comb begin
        sup_vld = 1'b0;
        sup_sel = '0;
        for (int i = CPUS - 1; i >= 0; i--) begin
            if (ccsnoophit[i] && (CW'(i) != req_idx)) begin
                sup_vld = 1'b1;
                sup_sel = CW'(i);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat;
        snoop_nxt   = ccsnoopaddr;
        beat_done   = 1'b0;
        dwait       = '1;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccexclusive = '0;
        l2REN       = 1'b0;
        l2WEN       = 1'b0;
        l2addr      = '0;
        l2store     = '0;

        case (state)
            IDLE: begin
                if (grant_vld) begin
                    beat_nxt = '0;
                    if (dWEN[grant_idx]) begin
                        state_nxt = WMEM;
                    end else begin
                        state_nxt = SNOOP;
                        snoop_nxt = daddr[grant_idx];
                    end
                end
            end
            SNOOP: begin
                ccwait = ~req_mask;
                if (op_readx)
                    ccinv = ~req_mask;
                beat_nxt = '0;
                if (sup_vld) begin
                    state_nxt = TRANSFER;
                    snoop_nxt = beat_addr;
                end else begin
                    state_nxt = RMEM;
                end
            end
            RMEM: begin
                l2REN                = 1'b1;
                l2addr               = beat_addr;
                ccexclusive[req_idx] = 1'b1;
                if (l2ready) begin
                    dload          = l2load;
                    dwait[req_idx] = 1'b0;
                    beat_done      = 1'b1;
                end
            end
            TRANSFER: begin
                ccwait[sup_idx]      = 1'b1;
                dload                = dstore[sup_idx];
                ccexclusive[req_idx] = op_readx;
                // dirty data shared without ownership must also reach L2
                if (sup_dirty && !op_readx) begin
                    l2WEN     = 1'b1;
                    l2addr    = beat_addr;
                    l2store   = dstore[sup_idx];
                    beat_done = l2ready;
                end else begin
                    beat_done = 1'b1;
                end
                if (beat_done)
                    dwait[req_idx] = 1'b0;
                if (beat_done && !last_beat)
                    snoop_nxt = next_addr;
            end
            WMEM: begin
                l2WEN   = 1'b1;
                l2addr  = beat_addr;
                l2store = dstore[req_idx];
                if (l2ready) begin
                    dwait[req_idx] = 1'b0;
                    beat_done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (beat_done) begin
            if (last_beat) begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end else begin
                beat_nxt = beat + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            beat        <= '0;
            req_idx     <= '0;
            sup_idx     <= '0;
            sup_dirty   <= 1'b0;
            op_readx    <= 1'b0;
            base_addr   <= '0;
            ccsnoopaddr <= '0;
        end else begin
            state       <= state_nxt;
            beat        <= beat_nxt;
            ccsnoopaddr <= snoop_nxt;
            if (state == IDLE && grant_vld) begin
                req_idx   <= grant_idx;
                op_readx  <= readX[grant_idx] & dREN[grant_idx] & ~dWEN[grant_idx];
                base_addr <= daddr[grant_idx];
            end
            if (state == SNOOP) begin
                sup_idx   <= sup_sel;
                sup_dirty <= sup_vld & ccdirty[sup_sel];
            end
        end
    end

endmodule
